// File: rtl/seg_capture.sv
`default_nettype none
// seg_capture: samples a multiplexed 7-segment display and assembles 4-digit BCD frames (valid/ready out).
// Revision: 1.0
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_digit_sel,
  input  logic [6:0]  i_segments,
  input  logic        i_ready,
  output logic [15:0] o_bcd,
  output logic        o_valid,
  output logic [3:0]  o_err,
  output logic        o_overrun
);

  localparam logic [7:0] c_STABLE    = 8'(STABLE_CYCLES);
  localparam logic [7:0] c_STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILTER = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_sel_m, r_sel_s;
  logic [6:0]  r_seg_m, r_seg_s;
  logic [10:0] r_prev;
  logic [7:0]  r_cnt;
  logic [3:0]  r_mask;
  logic [15:0] r_shadow_bcd;
  logic [3:0]  r_shadow_err;
  logic [15:0] r_bcd;
  logic [3:0]  r_err;
  logic        r_valid;
  logic        r_overrun;

  logic        w_changed;
  logic        w_onehot;
  logic [1:0]  w_idx;
  logic [3:0]  w_dec_val;
  logic        w_dec_err;
  logic        w_capture;
  logic        w_complete;
  logic [3:0]  w_mask_next;
  logic [15:0] w_shadow_bcd_next;
  logic [3:0]  w_shadow_err_next;

  assign w_changed = ({r_sel_s, r_seg_s} != r_prev);

  always_comb begin
    w_dec_val = 4'hF;
    w_dec_err = 1'b0;
    case (r_seg_s)
      7'b0000001: w_dec_val = 4'd0;
      7'b1001111: w_dec_val = 4'd1;
      7'b0010010: w_dec_val = 4'd2;
      7'b0000110: w_dec_val = 4'd3;
      7'b1001100: w_dec_val = 4'd4;
      7'b0100100: w_dec_val = 4'd5;
      7'b0100000: w_dec_val = 4'd6;
      7'b0001111: w_dec_val = 4'd7;
      7'b0000000: w_dec_val = 4'd8;
      7'b0000100: w_dec_val = 4'd9;
      default:    w_dec_err = 1'b1;
    endcase
  end

  // Only a single active-low enable names a digit; blanking and ghosting fall to default.
  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_sel_s)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) w_state_next = S_FILTER;
      end
      S_FILTER: begin
        if (!w_onehot) begin
          w_state_next = S_IDLE;
        end else if (!w_changed && (r_cnt == c_STABLE_M1)) begin
          w_capture    = 1'b1;
          w_state_next = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_changed) w_state_next = w_onehot ? S_FILTER : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_shadow_bcd_next = r_shadow_bcd;
    w_shadow_err_next = r_shadow_err;
    w_mask_next       = r_mask;
    w_complete        = 1'b0;
    if (w_capture) begin
      w_shadow_bcd_next[{w_idx, 2'b00} +: 4] = w_dec_val;
      w_shadow_err_next[w_idx]               = w_dec_err;
      w_mask_next = r_mask | (4'b0001 << w_idx);
      if (w_mask_next == 4'hF) begin
        w_complete  = 1'b1;
        w_mask_next = 4'h0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel_m      <= 4'h0;
      r_sel_s      <= 4'h0;
      r_seg_m      <= 7'h00;
      r_seg_s      <= 7'h00;
      r_prev       <= 11'h000;
      r_cnt        <= 8'h00;
      r_mask       <= 4'h0;
      r_shadow_bcd <= 16'h0000;
      r_shadow_err <= 4'h0;
      r_bcd        <= 16'h0000;
      r_err        <= 4'h0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sel_m      <= i_digit_sel;
      r_sel_s      <= r_sel_m;
      r_seg_m      <= i_segments;
      r_seg_s      <= r_seg_m;
      r_prev       <= {r_sel_s, r_seg_s};
      r_mask       <= w_mask_next;
      r_shadow_bcd <= w_shadow_bcd_next;
      r_shadow_err <= w_shadow_err_next;
      r_overrun    <= 1'b0;

      if (w_changed)              r_cnt <= 8'h00;
      else if (r_cnt != c_STABLE) r_cnt <= r_cnt + 8'd1;

      // A completed frame is only dropped when the previous one is still unaccepted.
      if (w_complete && (!r_valid || i_ready)) begin
        r_bcd   <= w_shadow_bcd_next;
        r_err   <= w_shadow_err_next;
        r_valid <= 1'b1;
      end else if (w_complete) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_bcd     = r_bcd;
  assign o_err     = r_err;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical synchronized samples needed to accept a digit (legal range 2..255).
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-004 i_digit_sel  input  4  multiplexed display digit enables, active-low, nominally one-hot; bit n selects digit n.
REQ-005 i_segments  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-006 i_ready  input  1  consumer accepts the current frame when high together with o_valid.
REQ-007 o_bcd  output  16  captured frame; digit n occupies bits [4n+3:4n].
REQ-008 o_valid  output  1  frame in o_bcd is pending for the consumer.
REQ-009 o_err  output  4  per-digit flag, bit n high when digit n of o_bcd held an undecodable pattern.
REQ-010 o_overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-011 i_digit_sel and i_segments shall each pass through a 2-flop synchronizer; all further logic uses the second-stage values (sel_s, seg_s).
REQ-012 Segment decode table (seg_s -> BCD): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
REQ-013 Any other seg_s pattern shall decode to 4'hF with the digit's error bit set.
REQ-014 A stability counter shall clear to 0 when {sel_s, seg_s} differs from its previous-cycle value, else increment, saturating at STABLE_CYCLES.
REQ-015 FSM states: S_IDLE, S_FILTER, S_LOCKED.
REQ-016 S_IDLE: if sel_s has exactly one bit low -> S_FILTER; otherwise stay.
REQ-017 S_FILTER: sel_s not one-hot-low -> S_IDLE; counter reaches STABLE_CYCLES-1 with inputs unchanged -> capture digit, -> S_LOCKED.
REQ-018 S_LOCKED: any change of {sel_s, seg_s} -> S_FILTER if new sel_s is one-hot-low, else S_IDLE; no further capture while locked.
REQ-019 Capture: write decoded value and error bit into shadow slot n, set captured-mask bit n; a repeat capture of slot n overwrites it.
REQ-020 Frame complete when captured mask = 4'b1111 after a capture; on that cycle the mask clears to 0.
REQ-021 On frame complete with o_valid low, or with o_valid and i_ready both high, the next cycle shall load o_bcd/o_err from the shadow and assert o_valid.
REQ-022 On frame complete with o_valid high and i_ready low, the frame is dropped, o_bcd/o_err unchanged, o_overrun pulses high for exactly one cycle.
REQ-023 o_valid shall stay high with o_bcd/o_err stable until i_ready is sampled high; it deasserts the next cycle unless REQ-021 reloads it.
REQ-024 Latency: from a stable input change at the pins to capture is 2 (sync) + STABLE_CYCLES cycles; o_valid rises one cycle after the completing capture.
REQ-025 All-high or multi-low i_digit_sel (blanking/ghosting) shall never cause a capture.

Reset
REQ-026 While i_rst_n is low at a rising edge: FSM -> S_IDLE, counter, mask, shadow and synchronizers -> 0, o_bcd=16'h0000, o_err=4'h0, o_valid=0, o_overrun=0.
REQ-027 Reset asserted mid-filter or mid-frame shall discard all partial captures; capture restarts from an empty mask after release.
REQ-028 The first capture after release requires a full STABLE_CYCLES window of synchronized samples.

Verification
REQ-029 Scan digits 0..3 with segments 0000110, 0100100, 0000000, 1001111, 8 cycles each, i_ready=1 -> o_bcd=16'h1853, o_err=0, o_valid one-cycle pulse.
REQ-030 Digit 2 driven with 1111111, others valid -> o_bcd[11:8]=4'hF, o_err=4'b0100.
REQ-031 Digit 0 held for only STABLE_CYCLES-1 cycles between changes -> no capture, o_valid stays 0.
REQ-032 i_ready=0, two full frames scanned -> first frame held in o_bcd, o_overrun pulses once at second completion, o_valid remains 1.
REQ-033 i_digit_sel=4'b1100 (two digits on) for 20 cycles -> FSM stays S_IDLE, mask unchanged.
REQ-034 Reset asserted after 3 of 4 digits captured, then a full frame scanned -> o_bcd equals the new frame only, o_valid one cycle after the 4th capture.
